// File: rtl/lock_pkg.sv
// lock_pkg: shared state type, counter-width helper and default constants for the passcode engine
package lock_pkg;
   typedef enum logic [2:0] {IDLE, ENROLL, CHECK, RESULT, LOCKOUT} state_t;
   localparam int DEF_DIGIT_W        = 2;
   localparam int DEF_MAX_LEN        = 4;
   localparam int DEF_MAX_TRIES      = 3;
   localparam int DEF_LOCKOUT_CYCLES = 16;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/lockout_timer.sv
// lockout_timer: loadable down-counter, done is high during the final lockout cycle
module lockout_timer
   import lock_pkg::*;
#(
   parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
   input  logic clk,
   input  logic system_reset,
   input  logic start,
   output logic done
);
   localparam int CW = cnt_w(LOCKOUT_CYCLES);
   logic [CW-1:0] count;
   always_ff @(posedge clk) begin
      if (system_reset) count <= '0;
      else count <= start ? CW'(LOCKOUT_CYCLES) : count != '0 ? count - CW'(1) : '0;
   end
   assign done = count == CW'(1);
endmodule

// File: rtl/passcode_engine.sv
// passcode_engine: keypad code enrollment, constant-time compare and failed-try lockout
module passcode_engine
   import lock_pkg::*;
#(
   parameter int DIGIT_W        = DEF_DIGIT_W,
   parameter int MAX_LEN        = DEF_MAX_LEN,
   parameter int MAX_TRIES      = DEF_MAX_TRIES,
   parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
   input  logic                        clk,
   input  logic                        system_reset,
   input  logic                        enroll_start,
   input  logic                        enroll_done,
   input  logic                        digit_valid,
   input  logic [DIGIT_W-1:0]          digit,
   input  logic                        entry_clear,
   input  logic                        compare_req,
   output logic                        correct_password,
   output logic                        incorrect_password,
   output logic                        locked,
   output logic                        busy,
   output logic                        entry_overflow,
   output logic [cnt_w(MAX_LEN)-1:0]   pw_length,
   output logic [cnt_w(MAX_LEN)-1:0]   in_count,
   output logic [cnt_w(MAX_TRIES)-1:0] tries_left
);
   localparam int LW = cnt_w(MAX_LEN);
   localparam int TW = cnt_w(MAX_TRIES);
   state_t state;
   logic [DIGIT_W-1:0] sys_code [MAX_LEN];
   logic [DIGIT_W-1:0] entry [MAX_LEN];
   logic [LW-1:0] idx;
   logic mismatch, diff, last, match, ready, lock_start, lock_done;
   logic take_enroll, take_cmp, take_clear, take_digit;
   always_comb begin
      ready       = state == IDLE || state == RESULT;
      take_enroll = ready && enroll_start;
      take_cmp    = ready && !enroll_start && compare_req;
      take_clear  = ready && !enroll_start && !compare_req && entry_clear;
      take_digit  = ready && !enroll_start && !compare_req && !entry_clear && digit_valid;
      diff = 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
         diff = diff | (idx == LW'(i) && LW'(i) < pw_length && sys_code[i] != entry[i]);
      last       = idx == LW'(MAX_LEN - 1);
      match      = !(mismatch || diff) && in_count == pw_length && pw_length != '0 && !entry_overflow;
      lock_start = state == CHECK && last && !match && tries_left <= TW'(1);
   end
   always_ff @(posedge clk) begin
      if (system_reset) begin
         state              <= IDLE;
         idx                <= '0;
         mismatch           <= 1'b0;
         pw_length          <= '0;
         in_count           <= '0;
         entry_overflow     <= 1'b0;
         correct_password   <= 1'b0;
         incorrect_password <= 1'b0;
         locked             <= 1'b0;
         tries_left         <= TW'(MAX_TRIES);
         for (int i = 0; i < MAX_LEN; i++) begin
            sys_code[i] <= '0;
            entry[i]    <= '0;
         end
      end else begin
         if (take_enroll || take_cmp || take_clear || take_digit) begin
            correct_password   <= 1'b0;
            incorrect_password <= 1'b0;
         end
         case (state)
            IDLE, RESULT: begin
               if (take_enroll) begin
                  state     <= ENROLL;
                  pw_length <= '0;
                  in_count  <= '0;
                  for (int i = 0; i < MAX_LEN; i++) sys_code[i] <= '0;
               end
               if (take_cmp) begin
                  state    <= CHECK;
                  idx      <= '0;
                  mismatch <= 1'b0;
               end
               if (take_clear) begin
                  in_count       <= '0;
                  entry_overflow <= 1'b0;
               end
               if (take_digit) begin
                  if (in_count == LW'(MAX_LEN)) entry_overflow <= 1'b1;
                  else begin
                     for (int i = 0; i < MAX_LEN; i++) if (in_count == LW'(i)) entry[i] <= digit;
                     in_count <= in_count + LW'(1);
                  end
               end
            end
            ENROLL: begin
               if (digit_valid && pw_length != LW'(MAX_LEN)) begin
                  for (int i = 0; i < MAX_LEN; i++) if (pw_length == LW'(i)) sys_code[i] <= digit;
                  pw_length <= pw_length + LW'(1);
               end
               if (enroll_done) state <= IDLE;
            end
            CHECK: begin
               // every index is visited regardless of data so the compare time never leaks the match position
               idx      <= last ? idx : idx + LW'(1);
               mismatch <= mismatch || diff;
               if (last) begin
                  state              <= lock_start ? LOCKOUT : RESULT;
                  correct_password   <= match;
                  incorrect_password <= !match;
                  locked             <= lock_start;
                  tries_left         <= match ? TW'(MAX_TRIES) : tries_left != '0 ? tries_left - TW'(1) : '0;
                  in_count           <= '0;
                  entry_overflow     <= 1'b0;
               end
            end
            LOCKOUT: begin
               if (lock_done) begin
                  state              <= IDLE;
                  locked             <= 1'b0;
                  tries_left         <= TW'(MAX_TRIES);
                  correct_password   <= 1'b0;
                  incorrect_password <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign busy = state == CHECK || state == LOCKOUT;
   lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_timer (
      .clk          (clk),
      .system_reset (system_reset),
      .start        (lock_start),
      .done         (lock_done)
   );
endmodule

// File: tb/tb_passcode_engine.sv
// tb_passcode_engine: directed scenarios checked against a deadline-based behavioural model
module tb_passcode_engine;
   localparam int MAX_LEN   = 4;
   localparam int MAX_TRIES = 3;
   localparam int LOCK      = 16;
   logic clk = 1'b0;
   logic system_reset, enroll_start, enroll_done, digit_valid, entry_clear, compare_req;
   logic [1:0] digit;
   logic correct_password, incorrect_password, locked, busy, entry_overflow;
   logic [2:0] pw_length, in_count;
   logic [1:0] tries_left;
   int checks = 0;
   int errors = 0;
   passcode_engine #(.DIGIT_W(2), .MAX_LEN(MAX_LEN), .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCK)) dut (
      .clk                (clk),
      .system_reset       (system_reset),
      .enroll_start       (enroll_start),
      .enroll_done        (enroll_done),
      .digit_valid        (digit_valid),
      .digit              (digit),
      .entry_clear        (entry_clear),
      .compare_req        (compare_req),
      .correct_password   (correct_password),
      .incorrect_password (incorrect_password),
      .locked             (locked),
      .busy               (busy),
      .entry_overflow     (entry_overflow),
      .pw_length          (pw_length),
      .in_count           (in_count),
      .tries_left         (tries_left)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // model: digit lists plus deadlines for when a pending result or lockout resolves
   int cyc = 0, clen = 0, elen = 0, tries = MAX_TRIES, check_end = -1, lock_end = -1;
   int code_d [MAX_LEN];
   int ent_d [MAX_LEN];
   bit ovf = 0, cor = 0, inc = 0, lck = 0, enrolling = 0, pend = 0, live = 0;
   function automatic bit entry_matches();
      if (clen == 0 || ovf || elen != clen) return 1'b0;
      for (int i = 0; i < clen; i++) if (ent_d[i] != code_d[i]) return 1'b0;
      return 1'b1;
   endfunction
   always @(posedge clk) begin
      cyc++;
      if (system_reset) begin
         live = 1; clen = 0; elen = 0; ovf = 0; cor = 0; inc = 0; lck = 0;
         enrolling = 0; tries = MAX_TRIES; check_end = -1; lock_end = -1;
      end else if (lck) begin
         if (cyc == lock_end) begin
            lck = 0; tries = MAX_TRIES; cor = 0; inc = 0;
         end
      end else if (check_end >= 0) begin
         if (cyc == check_end) begin
            check_end = -1; elen = 0; ovf = 0; cor = pend; inc = !pend;
            if (pend) tries = MAX_TRIES;
            else begin
               tries = tries - 1;
               if (tries == 0) begin
                  lck = 1;
                  lock_end = cyc + LOCK;
               end
            end
         end
      end else if (enrolling) begin
         if (digit_valid && clen < MAX_LEN) begin
            code_d[clen] = int'(digit);
            clen++;
         end
         if (enroll_done) enrolling = 0;
      end else begin
         if (enroll_start || compare_req || entry_clear || digit_valid) begin
            cor = 0; inc = 0;
         end
         if (enroll_start) begin
            enrolling = 1; clen = 0; elen = 0;
         end else if (compare_req) begin
            pend = entry_matches();
            check_end = cyc + MAX_LEN;
         end else if (entry_clear) begin
            elen = 0; ovf = 0;
         end else if (digit_valid) begin
            if (elen == MAX_LEN) ovf = 1;
            else begin
               ent_d[elen] = int'(digit);
               elen++;
            end
         end
      end
   end
   always @(negedge clk) begin
      if (live) begin
         chk("m_correct", correct_password, cor);
         chk("m_incorrect", incorrect_password, inc);
         chk("m_locked", locked, lck);
         chk("m_busy", busy, (check_end >= 0) || lck);
         chk("m_overflow", entry_overflow, ovf);
         chk("m_pw_length", pw_length, clen);
         chk("m_in_count", in_count, elen);
         chk("m_tries_left", tries_left, tries);
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic enroll(input int n, input logic [15:0] ds);
      enroll_start = 1; tick(); enroll_start = 0;
      for (int i = 0; i < n; i++) begin
         digit_valid = 1; digit = ds[2*i +: 2]; tick();
      end
      digit_valid = 0;
      enroll_done = 1; tick(); enroll_done = 0;
   endtask
   task automatic enter(input int n, input logic [15:0] ds);
      for (int i = 0; i < n; i++) begin
         digit_valid = 1; digit = ds[2*i +: 2]; tick();
      end
      digit_valid = 0;
   endtask
   task automatic compare_expect(input string tag, input bit ok, input int exp_tries);
      compare_req = 1; tick(); compare_req = 0;
      repeat (MAX_LEN - 1) tick();
      chk({tag, "_early"}, correct_password | incorrect_password, 0);
      chk({tag, "_busy"}, busy, 1);
      tick();
      chk({tag, "_correct"}, correct_password, ok);
      chk({tag, "_incorrect"}, incorrect_password, !ok);
      chk({tag, "_tries"}, tries_left, exp_tries);
   endtask
   initial begin
      system_reset = 1; enroll_start = 0; enroll_done = 0; digit_valid = 0;
      digit = 0; entry_clear = 0; compare_req = 0;
      tick(); tick();
      system_reset = 0;
      chk("rst_tries", tries_left, 3);
      chk("rst_outputs", {correct_password, incorrect_password, locked, busy, entry_overflow}, 0);
      chk("rst_counts", {pw_length, in_count}, 0);
      enroll(3, 16'b11_10_01);
      chk("enroll_len", pw_length, 3);
      enter(3, 16'b11_10_01);
      chk("entry_len", in_count, 3);
      compare_expect("match", 1, 3);
      chk("match_in_count", in_count, 0);
      enter(1, 16'b01);
      chk("digit_clears_result", correct_password, 0);
      enter(1, 16'b10);
      compare_expect("short", 0, 2);
      enter(5, 16'b00_11_11_10_01);
      chk("ovf_flag", entry_overflow, 1);
      chk("ovf_count", in_count, 4);
      entry_clear = 1; tick(); entry_clear = 0;
      chk("clear_ovf", entry_overflow, 0);
      chk("clear_count", in_count, 0);
      enter(5, 16'b00_11_11_10_01);
      compare_expect("ovf_cmp", 0, 1);
      enter(3, 16'b01_10_11);
      compare_expect("third", 0, 0);
      chk("lock_on", locked, 1);
      chk("lock_busy", busy, 1);
      for (int i = 0; i < LOCK - 1; i++) begin
         digit_valid = 1; digit = 2'(i); compare_req = (i == 3); enroll_start = (i == 7);
         tick();
         chk("lock_hold", locked, 1);
      end
      digit_valid = 0; compare_req = 0; enroll_start = 0;
      chk("lock_digits_ignored", in_count, 0);
      tick();
      chk("lock_off", locked, 0);
      chk("lock_tries", tries_left, 3);
      chk("lock_result_clr", incorrect_password, 0);
      enroll(0, 16'b0);
      chk("empty_len", pw_length, 0);
      compare_expect("empty", 0, 2);
      enter(1, 16'b01);
      entry_clear = 1; digit_valid = 1; digit = 2; tick();
      entry_clear = 0; digit_valid = 0;
      chk("clear_wins", in_count, 0);
      enroll(5, 16'b01_00_11_10_01);
      chk("enroll_sat", pw_length, 4);
      enter(4, 16'b00_11_10_01);
      compare_expect("len4", 1, 3);
      enter(4, 16'b00_11_10_01);
      compare_req = 1; tick(); compare_req = 0;
      tick();
      system_reset = 1; tick(); system_reset = 0;
      repeat (3) tick();
      chk("abort_result", correct_password | incorrect_password, 0);
      chk("abort_len", pw_length, 0);
      chk("abort_tries", tries_left, 3);
      chk("abort_busy", busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/passcode_engine.md
PASSCODE_ENGINE -- requirements
Module: passcode_engine

Interface
REQ-001 The parameter DIGIT_W SHALL default to 2 and set the width of one keypad digit.
REQ-002 The parameter MAX_LEN SHALL default to 4 and set the maximum number of digits per code (>=1).
REQ-003 The parameter MAX_TRIES SHALL default to 3 and set the consecutive failed compares that trigger lockout (>=1).
REQ-004 The parameter LOCKOUT_CYCLES SHALL default to 16 and set the lockout duration in clk cycles (>=1).
REQ-005 Ports SHALL be, in this order:
- clk  in  1  sole clock; all logic on its rising edge
- system_reset  in  1  synchronous, active-high reset
- enroll_start  in  1  one-cycle strobe; begin storing a new system code
- enroll_done  in  1  one-cycle strobe; end enrollment
- digit_valid  in  1  one-cycle strobe; digit is valid this cycle
- digit  in  DIGIT_W  keypad value
- entry_clear  in  1  one-cycle strobe; discard the entered digits
- compare_req  in  1  one-cycle strobe; check entry against system code
- correct_password  out  1  level; last compare matched
- incorrect_password  out  1  level; last compare failed
- locked  out  1  lockout active
- busy  out  1  high in CHECK and LOCKOUT
- entry_overflow  out  1  sticky; a digit was dropped because the entry was full
- pw_length  out  clog2(MAX_LEN+1)  stored code length
- in_count  out  clog2(MAX_LEN+1)  digits entered
- tries_left  out  clog2(MAX_TRIES+1)  compares remaining before lockout

Function
REQ-006 The FSM SHALL have the states IDLE, ENROLL, CHECK, RESULT and LOCKOUT.
REQ-007 In IDLE or RESULT, enroll_start SHALL go to ENROLL and clear pw_length, in_count and the stored code; in that cycle it has priority over compare_req, digit_valid and entry_clear.
REQ-008 In ENROLL, digit_valid SHALL write digit to sys[pw_length] and increment pw_length; digits after MAX_LEN are ignored; enroll_done returns to IDLE; compare_req and entry_clear are ignored.
REQ-009 In IDLE or RESULT, digit_valid SHALL write in[in_count] and increment in_count; if in_count==MAX_LEN the digit is dropped and entry_overflow is set.
REQ-010 In IDLE or RESULT, entry_clear SHALL zero in_count and entry_overflow; if entry_clear and digit_valid arrive together, the clear wins and the digit is dropped.
REQ-011 compare_req in IDLE or RESULT SHALL enter CHECK, which lasts exactly MAX_LEN cycles whatever the data (constant time); the result appears MAX_LEN+1 cycles after the compare_req edge.
REQ-012 CHECK SHALL compare one index per cycle; indices >= pw_length do not count; the match condition is: all compared indices equal AND in_count==pw_length AND pw_length!=0 AND entry_overflow==0.
REQ-013 On leaving CHECK: on a match, set correct_password=1, incorrect_password=0 and tries_left=MAX_TRIES; otherwise set incorrect_password=1, correct_password=0 and decrement tries_left. In both cases in_count and entry_overflow clear.
REQ-014 A failed compare that brings tries_left to 0 SHALL go to LOCKOUT instead of RESULT, set locked=1 and start the lockout timer.
REQ-015 In LOCKOUT, every strobe input SHALL be ignored; after LOCKOUT_CYCLES cycles the block goes to IDLE with locked=0, tries_left=MAX_TRIES and both result outputs 0.
REQ-016 In RESULT, the result outputs SHALL hold until the next accepted digit_valid, entry_clear, enroll_start or compare_req, and clear in that same cycle.
REQ-017 Strobes arriving in CHECK SHALL be ignored.
REQ-018 All counters SHALL saturate and never wrap.

Reset
REQ-019 While system_reset is high at a clk edge, the block SHALL go to IDLE with: all outputs 0 except tries_left=MAX_TRIES; stored code and entry cleared; lockout timer cleared. Reset mid-CHECK or mid-LOCKOUT SHALL abort without producing a result.

Structure
REQ-020 The state enum, counter-width helpers and default parameter constants SHALL live in the shared package lock_pkg.
REQ-021 The lockout down-counter SHALL be a sub-module, lockout_timer (inputs start and LOCKOUT_CYCLES; output done).

Verification
REQ-022 Enroll 1,2,3 then enter 1,2,3 and compare -> correct_password=1 exactly 5 cycles after compare_req; tries_left=3.
REQ-023 Code 1,2,3 with entry 1,2 -> incorrect_password=1 after 5 cycles; tries_left=2.
REQ-024 Three wrong compares -> locked=1, busy=1 and digits ignored for 16 cycles, then locked=0 and tries_left=3.
REQ-025 Enter 5 digits with MAX_LEN=4 -> entry_overflow=1, in_count=4, next compare fails; entry_clear -> overflow=0.
REQ-026 Assert system_reset during CHECK cycle 2 -> no result pulse; pw_length=0; tries_left=3.
REQ-027 Compare with no enrolled code (pw_length=0) -> incorrect_password=1.
